// File: rtl/ai_mc_cmd_split.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ai_mc_cmd_split : splits one request into MAX_BURST/BOUNDARY-legal bursts.
// Revision 1.0
// ----------------------------------------------------------------------------
module ai_mc_cmd_split #(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   parameter int BOUNDARY  = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rd_cmd_valid,
   input  logic              rd_cmd_ready,
   output logic [ADDR_W-1:0] rd_cmd_addr,
   output logic [LEN_W-1:0]  rd_cmd_len,
   output logic              wr_cmd_valid,
   input  logic              wr_cmd_ready,
   output logic [ADDR_W-1:0] wr_cmd_addr,
   output logic [LEN_W-1:0]  wr_cmd_len,
   output logic              cmd_last,
   output logic              busy,
   output logic              err_zero_len,
   output logic              err_misalign
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CW    = (ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SPLIT = 1'b1;

   localparam logic [ADDR_W-1:0] C_LOW_MASK = ADDR_W'(BYTES - 1);
   localparam logic [ADDR_W-1:0] C_BND_MASK = ADDR_W'(BOUNDARY - 1);
   localparam logic [CW-1:0]     C_BND      = CW'(BOUNDARY);
   localparam logic [CW-1:0]     C_MAXB     = CW'(MAX_BURST);

   logic [0:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic              err_zero_q, err_zero_d;
   logic              err_mis_q, err_mis_d;

   logic [ADDR_W-1:0] w_off;
   logic [CW-1:0]     w_room;
   logic [CW-1:0]     w_cap;
   logic [CW-1:0]     w_rem;
   logic [CW-1:0]     w_blen_ext;
   logic [LEN_W-1:0]  w_blen;
   logic [ADDR_W-1:0] w_step;
   logic              w_last;
   logic              w_hs;

   // Burst sizing depends only on registered state, never on the ready inputs.
   always_comb begin
      w_off      = cur_addr_q & C_BND_MASK;
      w_room     = (C_BND - CW'(w_off)) >> OFF_W;
      w_cap      = (w_room < C_MAXB) ? w_room : C_MAXB;
      w_rem      = CW'(rem_q);
      w_blen_ext = (w_rem < w_cap) ? w_rem : w_cap;
      w_blen     = LEN_W'(w_blen_ext);
      w_step     = ADDR_W'(w_blen) << OFF_W;
      w_last     = (rem_q == w_blen);
      w_hs       = (state_q == S_SPLIT) && (we_q ? wr_cmd_ready : rd_cmd_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         cur_addr_q <= '0;
         rem_q      <= '0;
         err_zero_q <= 1'b0;
         err_mis_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         cur_addr_q <= cur_addr_d;
         rem_q      <= rem_d;
         err_zero_q <= err_zero_d;
         err_mis_q  <= err_mis_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      cur_addr_d = cur_addr_q;
      rem_d      = rem_q;
      err_zero_d = 1'b0;
      err_mis_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_len == '0) begin
                  err_zero_d = 1'b1;
               end else begin
                  we_d       = req_we;
                  cur_addr_d = req_addr & ~C_LOW_MASK;
                  rem_d      = req_len;
                  err_mis_d  = |(req_addr & C_LOW_MASK);
                  state_d    = S_SPLIT;
               end
            end
         end
         S_SPLIT: begin
            if (w_hs) begin
               cur_addr_d = cur_addr_q + w_step;
               rem_d      = rem_q - w_blen;
               if (w_last) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == S_IDLE);
      busy         = (state_q == S_SPLIT);
      rd_cmd_valid = 1'b0;
      rd_cmd_addr  = '0;
      rd_cmd_len   = '0;
      wr_cmd_valid = 1'b0;
      wr_cmd_addr  = '0;
      wr_cmd_len   = '0;
      cmd_last     = 1'b0;
      err_zero_len = err_zero_q;
      err_misalign = err_mis_q;
      if (state_q == S_SPLIT) begin
         cmd_last = w_last;
         if (we_q) begin
            wr_cmd_valid = 1'b1;
            wr_cmd_addr  = cur_addr_q;
            wr_cmd_len   = w_blen;
         end else begin
            rd_cmd_valid = 1'b1;
            rd_cmd_addr  = cur_addr_q;
            rd_cmd_len   = w_blen;
         end
      end
   end

endmodule
`default_nettype wire
